fft_sequencer: RTL and testbench

FFT_SEQUENCER -- requirements
Module: fft_sequencer

---
 rtl/fft_pkg.sv | 30 +++
 rtl/fft_addr_gen.sv | 29 ++
 rtl/fft_sequencer.sv | 125 ++++++++++++
 tb/tb_fft_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - FFT sequencer state encoding and butterfly address helper
package fft_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CALC,
    ST_WRITE,
    ST_DONE
  } fft_state_t;

  typedef struct packed {
    logic [31:0] top;
    logic [31:0] bot;
    logic [31:0] tw;
  } fft_addr_t;

  // Radix-2 DIT indices for butterfly j of stage s in an N = 2**log2n transform.
  function automatic fft_addr_t fft_addr(input int unsigned s, input int unsigned j,
                                         input int unsigned log2n);
    int unsigned half;
    int unsigned k;
    half = 32'd1 << s;
    k = j & (half - 32'd1);
    fft_addr.top = ((j >> s) << (s + 32'd1)) + k;
    fft_addr.bot = fft_addr.top + half;
    fft_addr.tw  = k << (log2n - 32'd1 - s);
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// rtl/fft_addr_gen.sv - combinational top/bottom/twiddle address generator
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N = 9,
  parameter int SW    = $clog2(LOG2N)
) (
  input  logic [SW-1:0]    s,
  input  logic [LOG2N-2:0] j,
  output logic [LOG2N-1:0] top,
  output logic [LOG2N-1:0] bot,
  output logic [LOG2N-2:0] tw
);

  fft_addr_t a;
  logic      unused_bits;

  always_comb begin
    a = fft_addr(32'(s), 32'(j), LOG2N);
  end

  assign top = a.top[LOG2N-1:0];
  assign bot = a.bot[LOG2N-1:0];
  assign tw  = a.tw[LOG2N-2:0];

  // Upper bits are always zero for legal (s, j); folded here only to keep them referenced.
  assign unused_bits = ^{a.top[31:LOG2N], a.bot[31:LOG2N], a.tw[31:LOG2N-1]};

endmodule

// File: rtl/fft_sequencer.sv
// rtl/fft_sequencer.sv - in-place radix-2 DIT FFT sequencer driving RAM, ROM and external butterfly
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int LOG2N = 9
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [LOG2N-1:0]          rd_addr_a,
  output logic [LOG2N-1:0]          rd_addr_b,
  input  logic [WIDTH-1:0]          rd_data_a,
  input  logic [WIDTH-1:0]          rd_data_b,
  output logic [LOG2N-2:0]          tw_addr,
  input  logic [WIDTH-1:0]          tw_data,
  output logic [WIDTH-1:0]          bf_a,
  output logic [WIDTH-1:0]          bf_b,
  output logic [WIDTH-1:0]          bf_w,
  input  logic [WIDTH-1:0]          bf_sum,
  input  logic [WIDTH-1:0]          bf_diff,
  output logic                      wr_en,
  output logic [LOG2N-1:0]          wr_addr_a,
  output logic [LOG2N-1:0]          wr_addr_b,
  output logic [WIDTH-1:0]          wr_data_a,
  output logic [WIDTH-1:0]          wr_data_b,
  output logic [$clog2(LOG2N)-1:0]  stage
);

  localparam int              SW     = $clog2(LOG2N);
  localparam logic [SW-1:0]    S_LAST = SW'(LOG2N - 1);
  localparam logic [LOG2N-2:0] J_LAST = '1;

  fft_state_t       state;
  logic [SW-1:0]    s;
  logic [LOG2N-2:0] j;
  logic [LOG2N-1:0] top;
  logic [LOG2N-1:0] bot;
  logic [LOG2N-2:0] tw;

  fft_addr_gen #(
    .LOG2N (LOG2N),
    .SW    (SW)
  ) u_addr_gen (
    .s   (s),
    .j   (j),
    .top (top),
    .bot (bot),
    .tw  (tw)
  );

  // Memory and butterfly operands are gated by state so idle/reset presents all zeros.
  assign rd_addr_a = (state == ST_READ) ? top : '0;
  assign rd_addr_b = (state == ST_READ) ? bot : '0;
  assign tw_addr   = (state == ST_READ) ? tw  : '0;
  assign bf_a      = (state == ST_CALC) ? rd_data_a : '0;
  assign bf_b      = (state == ST_CALC) ? rd_data_b : '0;
  assign bf_w      = (state == ST_CALC) ? tw_data   : '0;
  assign stage     = s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      s         <= '0;
      j         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr_a <= '0;
      wr_addr_b <= '0;
      wr_data_a <= '0;
      wr_data_b <= '0;
    end else begin
      done      <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr_a <= '0;
      wr_addr_b <= '0;
      wr_data_a <= '0;
      wr_data_b <= '0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_READ;
            busy  <= 1'b1;
          end
        end
        ST_READ: state <= ST_CALC;
        ST_CALC: begin
          // Butterfly results are captured straight into the write-port registers.
          state     <= ST_WRITE;
          wr_en     <= 1'b1;
          wr_addr_a <= top;
          wr_addr_b <= bot;
          wr_data_a <= bf_sum;
          wr_data_b <= bf_diff;
        end
        ST_WRITE: begin
          if (j == J_LAST && s == S_LAST) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            s     <= '0;
            j     <= '0;
          end else begin
            state <= ST_READ;
            if (j == J_LAST) begin
              j <= '0;
              s <= s + 1'b1;
            end else begin
              j <= j + 1'b1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_sequencer.sv
// tb/tb_fft_sequencer.sv - self-checking bench for fft_sequencer with RAM, ROM and butterfly models
module tb_fft_sequencer;
  import fft_pkg::*;

  localparam int WIDTH = 36;
  localparam int LOG2N = 3;
  localparam int N     = 8;
  localparam int SW    = $clog2(LOG2N);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             busy, done, wr_en;
  logic [LOG2N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [LOG2N-2:0] tw_addr;
  logic [WIDTH-1:0] rd_data_a, rd_data_b, tw_data;
  logic [WIDTH-1:0] bf_a, bf_b, bf_w, bf_sum, bf_diff, wr_data_a, wr_data_b;
  logic [SW-1:0]    stage;

  logic             ld_en = 1'b0;
  logic [LOG2N-1:0] ld_addr = '0;
  logic [WIDTH-1:0] ld_data = '0;
  logic [WIDTH-1:0] ram [N];

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int top;
    int bot;
    int tw;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  fft_sequencer #(.WIDTH(WIDTH), .LOG2N(LOG2N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .tw_addr   (tw_addr),
    .tw_data   (tw_data),
    .bf_a      (bf_a),
    .bf_b      (bf_b),
    .bf_w      (bf_w),
    .bf_sum    (bf_sum),
    .bf_diff   (bf_diff),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .wr_data_a (wr_data_a),
    .wr_data_b (wr_data_b),
    .stage     (stage)
  );

  function automatic logic [35:0] tw_rom(input logic [1:0] k);
    int re, im;
    case (k)
      2'd0:    begin re = 32768;  im = 0;      end
      2'd1:    begin re = 23170;  im = -23170; end
      2'd2:    begin re = 0;      im = -32768; end
      default: begin re = -23170; im = -23170; end
    endcase
    return {18'(re), 18'(im)};
  endfunction

  function automatic logic [71:0] bfly(input logic [35:0] a, input logic [35:0] b,
                                       input logic [35:0] w);
    longint ar, ai, br, bi, wr, wi, pr, pi;
    ar = longint'($signed(a[35:18]));
    ai = longint'($signed(a[17:0]));
    br = longint'($signed(b[35:18]));
    bi = longint'($signed(b[17:0]));
    wr = longint'($signed(w[35:18]));
    wi = longint'($signed(w[17:0]));
    pr = (br * wr - bi * wi) >>> 15;
    pi = (br * wi + bi * wr) >>> 15;
    return {18'(ar + pr), 18'(ai + pi), 18'(ar - pr), 18'(ai - pi)};
  endfunction

  assign {bf_sum, bf_diff} = bfly(bf_a, bf_b, bf_w);

  always @(posedge clk) begin
    rd_data_a <= ram[rd_addr_a];
    rd_data_b <= ram[rd_addr_b];
    tw_data   <= tw_rom(tw_addr);
    if (ld_en) begin
      ram[ld_addr] <= ld_data;
    end else if (wr_en) begin
      ram[wr_addr_a] <= wr_data_a;
      ram[wr_addr_b] <= wr_data_b;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push_expected();
    exp_t e;
    for (int s = 0; s < LOG2N; s++) begin
      int half;
      half = 1 << s;
      for (int base = 0; base < N; base += 2 * half) begin
        for (int k = 0; k < half; k++) begin
          e.top = base + k;
          e.bot = base + k + half;
          e.tw  = k * (N / (2 * half));
          sbq.push_back(e);
        end
      end
    end
  endtask

  // Monitor: READ is the first busy cycle after idle or after a write.
  bit prev_busy = 1'b0;
  bit prev_wr = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sbq.delete();
      prev_busy = 1'b0;
      prev_wr = 1'b0;
    end else begin
      if (busy && (!prev_busy || prev_wr)) begin
        if (sbq.size() == 0) begin
          chk("unexpected_read", 64'(1), 64'(0));
        end else begin
          chk("rd_addr_a", 64'(rd_addr_a), 64'(sbq[0].top));
          chk("rd_addr_b", 64'(rd_addr_b), 64'(sbq[0].bot));
          chk("tw_addr", 64'(tw_addr), 64'(sbq[0].tw));
        end
      end
      if (wr_en) begin
        if (sbq.size() == 0) begin
          chk("unexpected_write", 64'(1), 64'(0));
        end else begin
          e = sbq.pop_front();
          chk("wr_addr_a", 64'(wr_addr_a), 64'(e.top));
          chk("wr_addr_b", 64'(wr_addr_b), 64'(e.bot));
        end
      end
      prev_busy = busy;
      prev_wr = wr_en;
    end
  end

  task automatic load(input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] wrest);
    for (int i = 0; i < N; i++) begin
      ld_en = 1'b1;
      ld_addr = LOG2N'(i);
      ld_data = (i == 0) ? w0 : wrest;
      @(posedge clk); #1;
    end
    ld_en = 1'b0;
  endtask

  task automatic run(input string tag, input bit pulse_in_calc);
    int busy_cyc, done_cyc;
    busy_cyc = 0;
    done_cyc = 0;
    push_expected();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (busy) busy_cyc++;
      if (done) done_cyc++;
      if (pulse_in_calc && busy_cyc == 14 && busy) begin
        chk({tag, "_calc_stage"}, 64'(stage), 64'(1));
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done_cyc > 0 && !done) break;
      @(posedge clk); #1;
    end
    chk({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(36));
    chk({tag, "_done_cycles"}, 64'(done_cyc), 64'(1));
    chk({tag, "_idle_busy"}, 64'(busy), 64'(0));
    chk({tag, "_sb_empty"}, 64'(sbq.size()), 64'(0));
  endtask

  initial begin
    fft_addr_t a;
    int fd, sb;

    #12;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_stage", 64'(stage), 64'(0));
    chk("rst_rd_addr_b", 64'(rd_addr_b), 64'(0));
    chk("rst_wr_data_a", 64'(wr_data_a), 64'(0));
    chk("rst_bf_a", 64'(bf_a), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    a = fft_addr(0, 0, 3);
    chk("s0j0_top", 64'(a.top), 64'(0));
    chk("s0j0_bot", 64'(a.bot), 64'(1));
    chk("s0j0_tw", 64'(a.tw), 64'(0));
    a = fft_addr(1, 3, 3);
    chk("s1j3_top", 64'(a.top), 64'(5));
    chk("s1j3_bot", 64'(a.bot), 64'(7));
    chk("s1j3_tw", 64'(a.tw), 64'(2));
    a = fft_addr(2, 3, 3);
    chk("s2j3_top", 64'(a.top), 64'(3));
    chk("s2j3_bot", 64'(a.bot), 64'(7));
    chk("s2j3_tw", 64'(a.tw), 64'(3));

    // Impulse: every bin equals the impulse value.
    load({18'h08000, 18'h00000}, '0);
    run("impulse", 1'b0);
    for (int i = 0; i < N; i++) chk($sformatf("impulse_ram%0d", i), 64'(ram[i]), 64'h2_0000_0000);

    // Constant input: all energy lands in bin 0 (8 * 0x01000); start during CALC is ignored.
    load({18'h01000, 18'h00000}, {18'h01000, 18'h00000});
    run("dc", 1'b1);
    chk("dc_ram0", 64'(ram[0]), 64'h2_0000_0000);
    for (int i = 1; i < N; i++) chk($sformatf("dc_ram%0d", i), 64'(ram[i]), 64'(0));

    // Reset during a stage-1 write aborts at once.
    push_expected();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100 && !(stage == 1 && wr_en); c++) begin
      @(posedge clk); #1;
    end
    chk("abort_reached_s1_write", 64'(stage == 1 && wr_en), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("abort_wr_en", 64'(wr_en), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_stage", 64'(stage), 64'(0));
    @(posedge clk); #1;
    chk("abort_hold_done", 64'(done), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    run("after_abort", 1'b0);

    // Start held high: back-to-back transforms separated by one idle cycle.
    push_expected();
    push_expected();
    fd = -1;
    sb = -1;
    start = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 100; c++) begin
      if (done && fd < 0) fd = c;
      if (fd >= 0 && busy) begin
        sb = c;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("b2b_first_done", 64'(fd), 64'(36));
    chk("b2b_second_start", 64'(sb), 64'(38));
    fd = -1;
    for (int c = 0; c < 100; c++) begin
      if (done) begin
        fd = c;
        break;
      end
      @(posedge clk); #1;
    end
    chk("b2b_second_done", 64'(fd), 64'(36));
    @(posedge clk); #1;
    chk("b2b_sb_empty", 64'(sbq.size()), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_stays_idle", 64'(busy), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
